dino_scene_compositor: RTL

// Pixel compositor and game-state engine for the dino runner: overlays one dino sprite and NUM_OBST

---
 rtl/dino_scene_compositor.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/dino_scene_compositor.sv
// Dino runner compositor: overlays the dino and NUM_OBST scrolling obstacles on a 1-bpp background,
// runs the IDLE/RUN/OVER game FSM and detects pixel-exact collisions. Optional: NIGHT_MODE_EN.
module dino_scene_compositor #(
    parameter int NUM_OBST    = 3,
    parameter int DINO_W      = 60,
    parameter int DINO_H      = 60,
    parameter int OBST_W      = 49,
    parameter int OBST_H      = 80,
    parameter int GROUND      = 335,
    parameter int SPAWN_X     = 550,
    parameter int SPACING     = 260,
    parameter int MIN_X       = 10,
    parameter int SPEED_INIT  = 1,
    parameter int SPEED_MAX   = 8,
    parameter int RAMP_FRAMES = 512,
    parameter int SCORE_DIV   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pix_en,
    input  logic                     frame_end,
    input  logic                     active,
    input  logic [9:0]               x,
    input  logic [8:0]               y,
    input  logic [9:0]               dino_x,
    input  logic [8:0]               dino_y,
    input  logic                     start,
    input  logic                     bg_px,
    input  logic                     dino_px,
    input  logic [NUM_OBST-1:0]      obst_px,
    output logic [18:0]              img_addr,
    output logic [11:0]              dino_addr,
    output logic [13*NUM_OBST-1:0]   obst_addr,
    output logic [11:0]              rgb,
    output logic                     game_over,
    output logic [15:0]              score,
    output logic [3:0]               speed
);
    localparam int OBST_Y = GROUND - OBST_H;
    localparam int DIV_W  = $clog2(SCORE_DIV + 1);
    localparam int RAMP_W = $clog2(RAMP_FRAMES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_OVER} state_t;

    state_t                state_q, state_d;
    logic [10:0]           ox_q [NUM_OBST];
    logic [10:0]           ox_d [NUM_OBST];
    logic [15:0]           score_q, score_d;
    logic [3:0]            speed_q, speed_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [RAMP_W-1:0]     ramp_cnt_q, ramp_cnt_d;
    logic [9:0]            dx_q, dx_d;
    logic [8:0]            dy_q, dy_d;
    logic [18:0]           img_addr_q, img_addr_d;
    logic [11:0]           dino_addr_q, dino_addr_d;
    logic [13*NUM_OBST-1:0] obst_addr_q, obst_addr_d;
    logic                  dino_in_q, dino_in_d;
    logic [NUM_OBST-1:0]   obst_in_q, obst_in_d;
    logic                  act_q, act_d;
    logic [11:0]           rgb_q, rgb_d;
    logic                  game_over_q, game_over_d;

    logic                  dino_win;
    logic [11:0]           dino_addr_c;
    logic [NUM_OBST-1:0]   obst_win;
    logic [12:0]           obst_addr_c [NUM_OBST];
    logic                  hit_obst, collide, fg;
    logic [11:0]           pix_colour;

    assign dino_win = (x >= dx_q) && ({1'b0, x} < {1'b0, dx_q} + 11'(DINO_W)) &&
                      (y >= dy_q) && ({1'b0, y} < {1'b0, dy_q} + 10'(DINO_H));
    assign dino_addr_c = dino_win ?
        ({3'b0, y} - {3'b0, dy_q}) * 12'(DINO_W) + ({2'b0, x} - {2'b0, dx_q}) : 12'd0;

    // Channels parked beyond the right edge are not drawn at all.
    for (genvar gi = 0; gi < NUM_OBST; gi++) begin : g_obst
        assign obst_win[gi] = (ox_q[gi] < 11'd640) &&
                              ({1'b0, x} >= ox_q[gi]) && ({1'b0, x} < ox_q[gi] + 11'(OBST_W)) &&
                              (y >= 9'(OBST_Y)) && (y < 9'(GROUND));
        assign obst_addr_c[gi] = obst_win[gi] ?
            (13'(y) - 13'(OBST_Y)) * 13'(OBST_W) + (13'({1'b0, x}) - 13'(ox_q[gi])) : 13'd0;
    end

    // Stage-B terms: window flags from stage A, ROM bits returned for those addresses.
    assign hit_obst = |(obst_in_q & obst_px);
    assign fg       = (dino_in_q & dino_px) | hit_obst | bg_px;
    assign collide  = pix_en && (state_q == ST_RUN) && act_q && dino_in_q && dino_px && hit_obst;

    always_comb begin
        pix_colour = fg ? 12'h000 : 12'hFFF;
`ifdef NIGHT_MODE_EN
        if (score_q[8]) pix_colour = ~pix_colour;
`endif
        if (!act_q) pix_colour = 12'h000;
    end

    always_comb begin
        state_d     = state_q;
        ox_d        = ox_q;
        score_d     = score_q;
        speed_d     = speed_q;
        div_cnt_d   = div_cnt_q;
        ramp_cnt_d  = ramp_cnt_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        img_addr_d  = img_addr_q;
        dino_addr_d = dino_addr_q;
        obst_addr_d = obst_addr_q;
        dino_in_d   = dino_in_q;
        obst_in_d   = obst_in_q;
        act_d       = act_q;
        rgb_d       = rgb_q;

        if (frame_end) begin
            dx_d = dino_x;
            dy_d = dino_y;
        end

        if (pix_en) begin
            img_addr_d  = 19'(x) + 19'(y) * 19'd640;
            dino_addr_d = dino_addr_c;
            dino_in_d   = dino_win;
            obst_in_d   = obst_win;
            act_d       = active;
            for (int i = 0; i < NUM_OBST; i++) obst_addr_d[13*i +: 13] = obst_addr_c[i];
            rgb_d       = pix_colour;
        end

        case (state_q)
            ST_RUN: begin
                // A collision on the same clock as frame_end freezes the scene before it moves.
                if (collide) begin
                    state_d = ST_OVER;
                end else if (frame_end) begin
                    for (int i = 0; i < NUM_OBST; i++) begin
                        if (ox_q[i] < 11'(MIN_X) + {7'd0, speed_q})
                            ox_d[i] = ox_q[i] - {7'd0, speed_q} + 11'(NUM_OBST * SPACING);
                        else
                            ox_d[i] = ox_q[i] - {7'd0, speed_q};
                    end
                    if (div_cnt_q == DIV_W'(SCORE_DIV - 1)) begin
                        div_cnt_d = '0;
                        if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
                    end else begin
                        div_cnt_d = div_cnt_q + DIV_W'(1);
                    end
                    if (ramp_cnt_q == RAMP_W'(RAMP_FRAMES - 1)) begin
                        ramp_cnt_d = '0;
                        if (speed_q < 4'(SPEED_MAX)) speed_d = speed_q + 4'd1;
                    end else begin
                        ramp_cnt_d = ramp_cnt_q + RAMP_W'(1);
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d    = ST_RUN;
                    score_d    = '0;
                    speed_d    = 4'(SPEED_INIT);
                    div_cnt_d  = '0;
                    ramp_cnt_d = '0;
                    for (int i = 0; i < NUM_OBST; i++) ox_d[i] = 11'(SPAWN_X + i * SPACING);
                end
            end
        endcase

        game_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < NUM_OBST; i++) ox_q[i] <= 11'(SPAWN_X + i * SPACING);
            score_q     <= '0;
            speed_q     <= 4'(SPEED_INIT);
            div_cnt_q   <= '0;
            ramp_cnt_q  <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            img_addr_q  <= '0;
            dino_addr_q <= '0;
            obst_addr_q <= '0;
            dino_in_q   <= 1'b0;
            obst_in_q   <= '0;
            act_q       <= 1'b0;
            rgb_q       <= '0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ox_q        <= ox_d;
            score_q     <= score_d;
            speed_q     <= speed_d;
            div_cnt_q   <= div_cnt_d;
            ramp_cnt_q  <= ramp_cnt_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            img_addr_q  <= img_addr_d;
            dino_addr_q <= dino_addr_d;
            obst_addr_q <= obst_addr_d;
            dino_in_q   <= dino_in_d;
            obst_in_q   <= obst_in_d;
            act_q       <= act_d;
            rgb_q       <= rgb_d;
            game_over_q <= game_over_d;
        end
    end

    assign img_addr  = img_addr_q;
    assign dino_addr = dino_addr_q;
    assign obst_addr = obst_addr_q;
    assign rgb       = rgb_q;
    assign game_over = game_over_q;
    assign score     = score_q;
    assign speed     = speed_q;
endmodule
